// File: rtl/calc_chip_if.sv
// Calculator front-panel bundle: operand/button inputs and
// seven-segment result outputs.
interface calc_chip_if #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
);
   logic                  button;
   logic                  op;
   logic [WIDTH-1:0]      X;
   logic [7*DIGITS-1:0]   seg;
   logic                  neg;
   logic                  busy;
   logic                  done;

   modport master (
      output button, op, X,
      input  seg, neg, busy, done
   );

   modport slave (
      input  button, op, X,
      output seg, neg, busy, done
   );
endinterface

// File: rtl/calc_chip.sv
// Two-operand add/subtract calculator with sequential double-dabble
// BCD conversion and blanked seven-segment display.
module calc_chip #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   calc_chip_if.slave  bus
);
   localparam int RW = WIDTH + 1;
   localparam int BW = 4 * DIGITS;
   localparam int SW = RW + BW;
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);

   typedef enum logic [1:0] {WAIT_A, WAIT_B, CONV} state_t;

   state_t              r_state, w_next;
   logic                r_s1, r_s2, r_s3;
   logic                w_press;
   logic [WIDTH-1:0]    r_a;
   logic [SW-1:0]       r_sh;
   logic [SW-1:0]       w_adj;
   logic [SW-1:0]       w_shf;
   logic [CW-1:0]       r_cnt;
   logic                r_sgn;
   logic                r_neg;
   logic                r_done;
   logic [7*DIGITS-1:0] r_seg;
   logic [7*DIGITS-1:0] w_seg;
   logic [RW-1:0]       w_res;
   logic                w_sgn;
   logic                w_lead;
   logic [3:0]          w_nib;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0:    enc = 7'h3F;
         4'd1:    enc = 7'h06;
         4'd2:    enc = 7'h5B;
         4'd3:    enc = 7'h4F;
         4'd4:    enc = 7'h66;
         4'd5:    enc = 7'h6D;
         4'd6:    enc = 7'h7D;
         4'd7:    enc = 7'h07;
         4'd8:    enc = 7'h7F;
         4'd9:    enc = 7'h6F;
         default: enc = 7'h00;
      endcase
   endfunction

   assign w_press = r_s2 & ~r_s3;

   // B arrives on the bus at its capture edge, so R is formed from X directly
   always_comb begin
      w_sgn = 1'b0;
      if (!bus.op)
         w_res = {1'b0, r_a} + {1'b0, bus.X};
      else if (r_a >= bus.X)
         w_res = {1'b0, r_a - bus.X};
      else begin
         w_res = {1'b0, bus.X - r_a};
         w_sgn = 1'b1;
      end
   end

   always_comb begin
      w_adj = r_sh;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_sh[RW+4*d +: 4] >= 4'd5)
            w_adj[RW+4*d +: 4] = r_sh[RW+4*d +: 4] + 4'd3;
      end
      w_shf = w_adj << 1;
   end

   always_comb begin
      w_seg  = '0;
      w_lead = 1'b1;
      w_nib  = 4'd0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         w_nib = r_sh[RW+4*d +: 4];
         if (w_nib != 4'd0)
            w_lead = 1'b0;
         if (!(w_lead && d > 0))
            w_seg[7*d +: 7] = enc(w_nib);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         WAIT_A:  if (w_press) w_next = WAIT_B;
         WAIT_B:  if (w_press) w_next = CONV;
         CONV:    if (r_cnt == LAST) w_next = WAIT_A;
         default: w_next = WAIT_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_A;
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_s1    <= bus.button;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_sh   <= '0;
         r_cnt  <= '0;
         r_sgn  <= 1'b0;
         r_neg  <= 1'b0;
         r_seg  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            WAIT_A: if (w_press) r_a <= bus.X;
            WAIT_B: if (w_press) begin
               r_sh  <= {{BW{1'b0}}, w_res};
               r_sgn <= w_sgn;
               r_cnt <= '0;
            end
            CONV: if (r_cnt == LAST) begin
               r_seg  <= w_seg;
               r_neg  <= r_sgn;
               r_done <= 1'b1;
            end else begin
               r_sh  <= w_shf;
               r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.seg  = r_seg;
   assign bus.neg  = r_neg;
   assign bus.busy = (r_state == CONV);
   assign bus.done = r_done;
endmodule

// File: tb/tb_calc_chip.sv
// Bench for calc_chip: WIDTH=4/DIGITS=2 and WIDTH=8/DIGITS=3 instances
// driven in lockstep and checked against an arithmetic display model.
module tb_calc_chip;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   calc_chip_if #(.WIDTH(4), .DIGITS(2)) b4 ();
   calc_chip_if #(.WIDTH(8), .DIGITS(3)) b8 ();

   calc_chip #(.WIDTH(4), .DIGITS(2)) u4 (
      .clk(clk), .rst_n(rst_n), .bus(b4.slave));
   calc_chip #(.WIDTH(8), .DIGITS(3)) u8 (
      .clk(clk), .rst_n(rst_n), .bus(b8.slave));

   int tests = 0;
   int fails = 0;
   logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic int mres(int a, int b, bit o);
      if (!o) return a + b;
      return (a >= b) ? a - b : b - a;
   endfunction

   function automatic logic [31:0] mseg(int r, int nd);
      logic [31:0] s;
      int p;
      s = 0;
      p = 1;
      for (int d = 0; d < nd; d++) begin
         if (d == 0 || r >= p)
            s = s | (32'(tbl[(r / p) % 10]) << (7 * d));
         p = p * 10;
      end
      return s;
   endfunction

   task automatic chk(input string t, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", t, obs, exp);
      end
   endtask

   task automatic drive(input int a4, input int a8, input bit o);
      b4.X  = a4[3:0];
      b8.X  = a8[7:0];
      b4.op = o;
      b8.op = o;
   endtask

   task automatic btn(input bit v);
      b4.button = v;
      b8.button = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int a4, input int a8, input bit o);
      @(negedge clk);
      drive(a4, a8, o);
      btn(1'b1);
      idle(3);
      btn(1'b0);
   endtask

   // called right after the B capture edge; poke presses during busy
   task automatic wait_done(input int a4, input int bb4, input int a8,
                            input int bb8, input bit o, input bit poke);
      int c;
      int t4;
      bit s4;
      bit s8;
      int r4;
      int r8;
      c  = 0;
      t4 = 0;
      s4 = 0;
      s8 = 0;
      r4 = mres(a4, bb4, o);
      r8 = mres(a8, bb8, o);
      chk("busy4_rise", b4.busy, 1);
      chk("busy8_rise", b8.busy, 1);
      while (!(s4 && s8) && c < 40) begin
         @(negedge clk);
         c++;
         if (poke && c == 1) begin
            drive(13, 171, o);
            btn(1'b1);
         end
         if (poke && c == 4)
            btn(1'b0);
         if (b4.done && !s4) begin
            s4 = 1;
            t4 = c;
            chk("lat4", c, 6);
            chk("seg4", 32'(b4.seg), mseg(r4, 2));
            chk("neg4", b4.neg, 32'(o && a4 < bb4));
            chk("busy4_fall", b4.busy, 0);
         end else if (s4 && c == t4 + 1) begin
            chk("pulse4", b4.done, 0);
         end
         if (b8.done && !s8) begin
            s8 = 1;
            chk("lat8", c, 10);
            chk("seg8", 32'(b8.seg), mseg(r8, 3));
            chk("neg8", b8.neg, 32'(o && a8 < bb8));
            chk("busy8_fall", b8.busy, 0);
         end
      end
      chk("done4_seen", 32'(s4), 1);
      chk("done8_seen", 32'(s8), 1);
      @(negedge clk);
      chk("pulse8", b8.done, 0);
      idle(2);
   endtask

   task automatic run(input int a4, input int bb4, input int a8,
                      input int bb8, input bit o);
      press(a4, a8, o);
      idle(3);
      press(bb4, bb8, o);
      wait_done(a4, bb4, a8, bb8, o, 1'b0);
   endtask

   initial begin
      int n4;
      int n8;
      drive(0, 0, 1'b0);
      btn(1'b0);
      idle(3);
      chk("rst_seg4", 32'(b4.seg), 0);
      chk("rst_neg4", b4.neg, 0);
      chk("rst_busy4", b4.busy, 0);
      chk("rst_done4", b4.done, 0);
      chk("rst_seg8", 32'(b8.seg), 0);
      chk("rst_busy8", b8.busy, 0);
      rst_n = 1'b1;
      idle(2);

      run(7, 9, 255, 255, 1'b0);
      run(15, 15, 100, 27, 1'b0);
      run(3, 9, 1, 200, 1'b1);
      run(5, 5, 77, 77, 1'b1);
      run(0, 0, 0, 0, 1'b0);

      // held button: X changes after the single legitimate capture
      @(negedge clk);
      drive(4, 40, 1'b0);
      btn(1'b1);
      idle(3);
      drive(9, 99, 1'b0);
      idle(17);
      btn(1'b0);
      idle(3);
      press(6, 60, 1'b0);
      wait_done(4, 6, 40, 60, 1'b0, 1'b0);

      // press during busy must not be taken as the next A
      press(2, 20, 1'b1);
      idle(3);
      press(11, 150, 1'b1);
      wait_done(2, 11, 20, 150, 1'b1, 1'b1);
      run(1, 2, 3, 4, 1'b1);

      // reset mid-conversion
      press(9, 200, 1'b1);
      idle(3);
      press(5, 100, 1'b1);
      idle(2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_seg4", 32'(b4.seg), 0);
      chk("mid_neg4", b4.neg, 0);
      chk("mid_busy4", b4.busy, 0);
      chk("mid_seg8", 32'(b8.seg), 0);
      chk("mid_neg8", b8.neg, 0);
      chk("mid_busy8", b8.busy, 0);
      idle(2);
      rst_n = 1'b1;
      n4 = 0;
      n8 = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (b4.done) n4++;
         if (b8.done) n8++;
      end
      chk("nodone4", n4, 0);
      chk("nodone8", n8, 0);
      run(8, 3, 42, 9, 1'b0);

      for (int i = 0; i < 12; i++) begin
         int a4;
         int bb4;
         int a8;
         int bb8;
         bit o;
         a4  = int'($urandom_range(0, 15));
         bb4 = int'($urandom_range(0, 15));
         a8  = int'($urandom_range(0, 255));
         bb8 = int'($urandom_range(0, 255));
         o   = 1'($urandom_range(0, 1));
         run(a4, bb4, a8, bb8, o);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
